// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-subset pipeline: ALU opcodes, shift types,
// forwarding selects, status-flag bit positions and the EX/MEM register layout.
package arm_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic        wb_en;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dest;
  } exmem_t;

  // Rotate right; a zero amount leaves the value untouched because the
  // left shift by 32 contributes nothing.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction

  // The unused select code 11 falls back to the register-file value.
  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] reg_val,
                                          input logic [31:0] mem_val, input logic [31:0] wb_val);
    case (sel)
      FWD_MEM: return mem_val;
      FWD_WB:  return wb_val;
      default: return reg_val;
    endcase
  endfunction

endpackage

// File: rtl/val2_generator.sv
// Second ALU operand: 12-bit address offset, rotated 8-bit immediate or shifted Rm.
// Purely combinational; no state, no stall interaction.
module val2_generator (
  input  logic [31:0] rm,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_en,
  output logic [31:0] val2
);
  import arm_pkg::*;

  logic [4:0]  rot_amt;
  logic [4:0]  sh_amt;
  logic [1:0]  sh_type;
  logic [31:0] imm8;

  assign rot_amt = {shift_operand[11:8], 1'b0};
  assign sh_amt  = shift_operand[11:7];
  assign sh_type = shift_operand[6:5];
  assign imm8    = {24'b0, shift_operand[7:0]};

  always_comb begin
    val2 = rm;
    if (mem_en) begin
      val2 = {20'b0, shift_operand};
    end else if (imm) begin
      val2 = ror32(imm8, rot_amt);
    end else begin
      case (sh_type)
        SH_LSL:  val2 = rm << sh_amt;
        SH_LSR:  val2 = rm >> sh_amt;
        SH_ASR:  val2 = $unsigned($signed(rm) >>> sh_amt);
        default: val2 = ror32(rm, sh_amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding, Val2, ALU, {N,Z,C,V} status and the EX/MEM register.
// One-cycle latency to the EX/MEM outputs; freeze holds all state, branch outputs stay combinational.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             wb_en_in,
  input  logic             mem_read_en_in,
  input  logic             mem_write_en_in,
  input  logic             B_in,
  input  logic             S_in,
  input  logic             imm_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic [WIDTH-1:0] PC_in,
  input  logic [WIDTH-1:0] val_Rn_in,
  input  logic [WIDTH-1:0] val_Rm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm_24_in,
  input  logic [3:0]       dest_in,
  input  logic [1:0]       sel_src1,
  input  logic [1:0]       sel_src2,
  input  logic [WIDTH-1:0] mem_fwd_val,
  input  logic [WIDTH-1:0] wb_fwd_val,
  output logic [3:0]       status_out,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_addr,
  output logic             wb_en,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] st_val,
  output logic [3:0]       dest
);
  import arm_pkg::*;

  exmem_t      exmem_q, exmem_d;
  logic [3:0]  status_q, status_d;

  logic [31:0] op_a, op_rm, val2, res;
  logic [32:0] sum33;
  logic        c_in, c_out, v_out;

  assign op_a  = fwd_mux(sel_src1, val_Rn_in, mem_fwd_val, wb_fwd_val);
  assign op_rm = fwd_mux(sel_src2, val_Rm_in, mem_fwd_val, wb_fwd_val);
  assign c_in  = status_q[FLAG_C];

  val2_generator u_val2 (
    .rm            (op_rm),
    .shift_operand (shift_operand_in),
    .imm           (imm_in),
    .mem_en        (mem_read_en_in | mem_write_en_in),
    .val2          (val2)
  );

  assign branch_taken = B_in;
  assign branch_addr  = PC_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  always_comb begin
    sum33 = '0;
    res   = '0;
    c_out = 1'b0;
    v_out = 1'b0;
    case (exe_cmd_in)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum33 = {1'b0, op_a} + {1'b0, val2};
        if (exe_cmd_in == CMD_ADC) sum33 = sum33 + {32'b0, c_in};
        res   = sum33[31:0];
        c_out = sum33[32];
        v_out = (op_a[31] == val2[31]) && (res[31] != op_a[31]);
      end
      CMD_SUB, CMD_SBC: begin
        sum33 = {1'b0, op_a} - {1'b0, val2};
        if (exe_cmd_in == CMD_SBC) sum33 = sum33 - {32'b0, ~c_in};
        res   = sum33[31:0];
        // Bit 32 is the borrow out of the 33-bit difference.
        c_out = ~sum33[32];
        v_out = (op_a[31] != val2[31]) && (res[31] != op_a[31]);
      end
      CMD_AND: res = op_a & val2;
      CMD_ORR: res = op_a | val2;
      CMD_EOR: res = op_a ^ val2;
      default: res = '0;
    endcase
  end

  always_comb begin
    exmem_d  = exmem_q;
    status_d = status_q;
    if (!freeze) begin
      exmem_d.wb_en        = wb_en_in;
      exmem_d.mem_read_en  = mem_read_en_in;
      exmem_d.mem_write_en = mem_write_en_in;
      exmem_d.alu_res      = res;
      exmem_d.st_val       = op_rm;
      exmem_d.dest         = dest_in;
      if (S_in) begin
        status_d[FLAG_N] = res[31];
        status_d[FLAG_Z] = (res == 32'b0);
        status_d[FLAG_C] = c_out;
        status_d[FLAG_V] = v_out;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_q  <= '0;
      status_q <= '0;
    end else begin
      exmem_q  <= exmem_d;
      status_q <= status_d;
    end
  end

  assign status_out   = status_q;
  assign wb_en        = exmem_q.wb_en;
  assign mem_read_en  = exmem_q.mem_read_en;
  assign mem_write_en = exmem_q.mem_write_en;
  assign alu_res      = exmem_q.alu_res;
  assign st_val       = exmem_q.st_val;
  assign dest         = exmem_q.dest;

endmodule

// File: tb/tb_exe_stage.sv
// Directed vector bench for exe_stage: opcode/flag table plus freeze, reset and branch sequences.
module tb_exe_stage;
  import arm_pkg::*;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic        wb_en_in, mem_read_en_in, mem_write_en_in, B_in, S_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in;
  logic [31:0] PC_in, val_Rn_in, val_Rm_in, mem_fwd_val, wb_fwd_val;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [1:0]  sel_src1, sel_src2;
  logic [3:0]  status_out, dest;
  logic        branch_taken, wb_en, mem_read_en, mem_write_en;
  logic [31:0] branch_addr, alu_res, st_val;

  int checks = 0;
  int errors = 0;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_en_in(wb_en_in), .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
    .B_in(B_in), .S_in(S_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in), .PC_in(PC_in),
    .val_Rn_in(val_Rn_in), .val_Rm_in(val_Rm_in), .shift_operand_in(shift_operand_in),
    .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val), .status_out(status_out),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .wb_en(wb_en),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .alu_res(alu_res),
    .st_val(st_val), .dest(dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic        s, imm, mr, mw, wb;
    logic [3:0]  dst;
    logic [31:0] rn, rm;
    logic [11:0] so;
    logic [1:0]  s1, s2;
    logic [31:0] mf, wf;
    logic [31:0] e_res;
    logic [3:0]  e_stat;
    logic [31:0] e_st;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic [3:0] cmd, input logic s, input logic imm,
                              input logic mr, input logic mw, input logic wb, input logic [3:0] dst,
                              input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] so,
                              input logic [1:0] s1, input logic [1:0] s2, input logic [31:0] mf,
                              input logic [31:0] wf, input logic [31:0] e_res,
                              input logic [3:0] e_stat, input logic [31:0] e_st);
    vec_t v;
    v.cmd = cmd; v.s = s; v.imm = imm; v.mr = mr; v.mw = mw; v.wb = wb; v.dst = dst;
    v.rn = rn; v.rm = rm; v.so = so; v.s1 = s1; v.s2 = s2; v.mf = mf; v.wf = wf;
    v.e_res = e_res; v.e_stat = e_stat; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exe_cmd_in = v.cmd; S_in = v.s; imm_in = v.imm; mem_read_en_in = v.mr;
    mem_write_en_in = v.mw; wb_en_in = v.wb; dest_in = v.dst; val_Rn_in = v.rn;
    val_Rm_in = v.rm; shift_operand_in = v.so; sel_src1 = v.s1; sel_src2 = v.s2;
    mem_fwd_val = v.mf; wb_fwd_val = v.wf; B_in = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_res, input logic [3:0] e_stat,
                         input logic [31:0] e_st, input logic [6:0] e_ctrl);
    chk({tag, " alu_res"}, alu_res, e_res);
    chk({tag, " status"}, {28'b0, status_out}, {28'b0, e_stat});
    chk({tag, " st_val"}, st_val, e_st);
    chk({tag, " ctrl"}, {25'b0, wb_en, mem_read_en, mem_write_en, dest}, {25'b0, e_ctrl});
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; freeze = 1'b0;
    v = mk(4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 12'h0, 0, 0, 0, 0, 0, 4'h0, 0);
    drive(v);
    PC_in = '0; signed_imm_24_in = '0;

    //                cmd      S  I  MR MW WB dst  Rn            Rm            so       s1     s2     mem_fwd      wb_fwd        exp_res       stat     exp_st
    vecs[0]  = mk(CMD_MOV, 0, 1, 0, 0, 1, 4'd1, 32'h0,        32'h0,        12'h1FF, 2'b00, 2'b00, 32'h0,       32'h0,        32'hC000_003F, 4'b0000, 32'h0);
    vecs[1]  = mk(CMD_MOV, 0, 1, 0, 0, 1, 4'd2, 32'h0,        32'h0,        12'h4FF, 2'b00, 2'b00, 32'h0,       32'h0,        32'hFF00_0000, 4'b0000, 32'h0);
    vecs[2]  = mk(CMD_ADD, 1, 1, 0, 0, 1, 4'd3, 32'h7FFF_FFFF, 32'h0,       12'h001, 2'b00, 2'b00, 32'h0,       32'h0,        32'h8000_0000, 4'b1001, 32'h0);
    vecs[3]  = mk(CMD_ADD, 0, 1, 0, 0, 1, 4'd4, 32'h1,        32'h0,        12'h001, 2'b00, 2'b00, 32'h0,       32'h0,        32'h2,         4'b1001, 32'h0);
    vecs[4]  = mk(CMD_SUB, 1, 1, 0, 0, 1, 4'd5, 32'h5,        32'h0,        12'h005, 2'b00, 2'b00, 32'h0,       32'h0,        32'h0,         4'b0110, 32'h0);
    vecs[5]  = mk(CMD_SBC, 0, 1, 0, 0, 1, 4'd6, 32'h5,        32'h0,        12'h003, 2'b00, 2'b00, 32'h0,       32'h0,        32'h2,         4'b0110, 32'h0);
    vecs[6]  = mk(CMD_MOV, 1, 1, 0, 0, 1, 4'd7, 32'h0,        32'h0,        12'h001, 2'b00, 2'b00, 32'h0,       32'h0,        32'h1,         4'b0000, 32'h0);
    vecs[7]  = mk(CMD_SBC, 1, 1, 0, 0, 1, 4'd8, 32'h5,        32'h0,        12'h003, 2'b00, 2'b00, 32'h0,       32'h0,        32'h1,         4'b0010, 32'h0);
    vecs[8]  = mk(CMD_ADC, 1, 1, 0, 0, 1, 4'd9, 32'hFFFF_FFFF, 32'h0,       12'h001, 2'b00, 2'b00, 32'h0,       32'h0,        32'h1,         4'b0010, 32'h0);
    vecs[9]  = mk(CMD_ADC, 0, 1, 0, 0, 1, 4'd10, 32'h1,       32'h0,        12'h002, 2'b00, 2'b00, 32'h0,       32'h0,        32'h4,         4'b0010, 32'h0);
    vecs[10] = mk(CMD_MVN, 1, 0, 0, 0, 1, 4'd11, 32'h0,       32'hF0,       12'h200, 2'b00, 2'b00, 32'h0,       32'h0,        32'hFFFF_F0FF, 4'b1000, 32'hF0);
    vecs[11] = mk(CMD_ORR, 0, 0, 0, 0, 1, 4'd12, 32'h1,       32'h8000_0000, 12'hFA0, 2'b00, 2'b00, 32'h0,      32'h0,        32'h1,         4'b1000, 32'h8000_0000);
    vecs[12] = mk(CMD_AND, 0, 0, 0, 0, 1, 4'd13, 32'hFFFF_0000, 32'h8000_0000, 12'h240, 2'b00, 2'b00, 32'h0,    32'h0,        32'hF800_0000, 4'b1000, 32'h8000_0000);
    vecs[13] = mk(CMD_EOR, 0, 0, 0, 0, 1, 4'd14, 32'h0F0F_0F0F, 32'h1234_5678, 12'h460, 2'b00, 2'b00, 32'h0,    32'h0,        32'h771D_3B59, 4'b1000, 32'h1234_5678);
    vecs[14] = mk(4'h0,    1, 1, 0, 0, 0, 4'd15, 32'h1234,    32'h0,        12'h0FF, 2'b00, 2'b00, 32'h0,       32'h0,        32'h0,         4'b0100, 32'h0);
    vecs[15] = mk(CMD_ADD, 0, 1, 0, 0, 1, 4'd1, 32'h99,       32'h0,        12'h004, 2'b01, 2'b00, 32'h10,      32'h0,        32'h14,        4'b0100, 32'h0);
    vecs[16] = mk(CMD_ADD, 0, 0, 0, 1, 0, 4'd2, 32'h1000,     32'hAAAA,     12'h408, 2'b00, 2'b10, 32'h0,       32'hDEAD_BEEF, 32'h1408,     4'b0100, 32'hDEAD_BEEF);
    vecs[17] = mk(CMD_ADD, 0, 0, 1, 0, 1, 4'd3, 32'h5,        32'h55,       12'h004, 2'b10, 2'b11, 32'h0,       32'h2000,     32'h2004,      4'b0100, 32'h55);
    vecs[18] = mk(CMD_SUB, 1, 1, 0, 0, 1, 4'd4, 32'h8000_0000, 32'h0,       12'h001, 2'b00, 2'b00, 32'h0,       32'h0,        32'h7FFF_FFFF, 4'b0011, 32'h0);
    vecs[19] = mk(CMD_ADD, 1, 1, 0, 0, 1, 4'd5, 32'hFFFF_FFFF, 32'h0,       12'h001, 2'b00, 2'b00, 32'h0,       32'h0,        32'h0,         4'b0110, 32'h0);

    // Async reset must clear outputs before any clock edge.
    #2;
    chk_all("reset", 32'h0, 4'h0, 32'h0, 7'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vecs[i].e_res, vecs[i].e_stat, vecs[i].e_st,
              {vecs[i].wb, vecs[i].mr, vecs[i].mw, vecs[i].dst});
    end

    // Same-cycle branch target, negative and positive offsets.
    B_in = 1'b1; PC_in = 32'h100; signed_imm_24_in = 24'hFFFFFE;
    #1;
    chk("branch_taken", {31'b0, branch_taken}, 32'h1);
    chk("branch_addr neg", branch_addr, 32'h0000_00F8);
    PC_in = 32'h200; signed_imm_24_in = 24'h000010;
    #1;
    chk("branch_addr pos", branch_addr, 32'h0000_0240);
    B_in = 1'b0;
    #1;
    chk("branch_taken clr", {31'b0, branch_taken}, 32'h0);

    v = mk(CMD_MOV, 0, 1, 0, 0, 1, 4'd6, 0, 32'h77, 12'h055, 0, 0, 0, 0, 0, 4'h0, 0);
    drive(v);
    @(negedge clk);
    chk_all("pre_freeze", 32'h55, 4'b0110, 32'h77, {3'b100, 4'd6});

    freeze = 1'b1;
    for (int c = 0; c < 3; c++) begin
      v = mk(CMD_MOV, 1, 1, 1, 0, 0, 4'd9 + 4'(c), 0, 32'h100 + c, 12'h0FF, 0, 0, 0, 0, 0, 4'h0, 0);
      drive(v);
      B_in = 1'b1; PC_in = 32'h1000 * (c + 1); signed_imm_24_in = 24'h1;
      #1;
      chk($sformatf("freeze%0d branch_addr", c), branch_addr, 32'h1000 * (c + 1) + 32'h4);
      @(negedge clk);
      chk_all($sformatf("freeze%0d", c), 32'h55, 4'b0110, 32'h77, {3'b100, 4'd6});
    end

    freeze = 1'b0;
    @(negedge clk);
    chk_all("unfreeze", 32'hFF, 4'b0000, 32'h102, {3'b010, 4'd11});

    freeze = 1'b1;
    v = mk(CMD_SUB, 1, 1, 0, 0, 1, 4'd3, 32'h1, 32'h0, 12'h002, 0, 0, 0, 0, 0, 4'h0, 0);
    drive(v);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_in_freeze", 32'h0, 4'h0, 32'h0, 7'h0);
    @(negedge clk);
    chk_all("rst_held", 32'h0, 4'h0, 32'h0, 7'h0);
    rst = 1'b0; freeze = 1'b0;

    // Bubble: all-zero ID/EX gives zero controls and a zero result.
    v = mk(4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 12'h0, 0, 0, 0, 0, 0, 4'h0, 0);
    drive(v);
    @(negedge clk);
    chk_all("bubble", 32'h0, 4'h0, 32'h0, 7'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
